// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - multi-cycle instruction fetch stage with PC and next-PC logic
//
// Purpose: holds the PC, fetches from a variable-latency instruction memory
// over a req/ack handshake, latches the instruction register and computes
// the next PC from the decoder's PCSrc select.
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   imem_req/addr     fetch request and address (address is pc)
//   imem_ack/rdata    memory accept and instruction word (same cycle)
//   PCSrc             next-PC select: 0 seq, 1 branch, 2 jump, 3 jr
//   branch_taken      branch condition result
//   rs_data           jr target register value
//   exec_ready        datapath has finished the current instruction
//   inst, OpCode, Funct, inst_valid, pc, pc_plus4   decode-side outputs
//   retired           count of completed instructions
//
// Optional: DELAY_SLOT_EN enables a MIPS branch delay slot.

module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic [1:0]  PCSrc,
    input  logic        branch_taken,
    input  logic [31:0] rs_data,
    input  logic        exec_ready,
    output logic [31:0] inst,
    output logic [5:0]  OpCode,
    output logic [5:0]  Funct,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {IDLE, REQ, EXEC} stateT;

    stateT       state;
    stateT       stateNext;
    logic [31:0] nextPc;
    logic [31:0] branchOff;
    logic        fetchDone;
    logic        retireNow;

`ifdef DELAY_SLOT_EN
    logic [31:0] pendingTarget;
    logic        pendingValid;
    logic        redirect;
`endif

    assign imem_addr = pc;
    assign OpCode    = inst[31:26];
    assign Funct     = inst[5:0];
    assign pc_plus4  = pc + 32'd4;
    assign branchOff = {{14{inst[15]}}, inst[15:0], 2'b00};

    always_comb begin
        nextPc = pc_plus4;
        case (PCSrc)
            2'd0: nextPc = pc_plus4;
            2'd1: nextPc = branch_taken ? (pc_plus4 + branchOff) : pc_plus4;
            2'd2: nextPc = {pc_plus4[31:28], inst[25:0], 2'b00};
            2'd3: nextPc = rs_data & ~32'h3;
            default: nextPc = pc_plus4;
        endcase
    end

`ifdef DELAY_SLOT_EN
    // Only a change of flow needs deferring; a not-taken branch is sequential.
    assign redirect = (PCSrc != 2'd0) && (nextPc != pc_plus4);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        imem_req   = 1'b0;
        inst_valid = 1'b0;
        fetchDone  = 1'b0;
        retireNow  = 1'b0;
        case (state)
            IDLE: stateNext = REQ;
            REQ: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    fetchDone = 1'b1;
                    stateNext = EXEC;
                end
            end
            EXEC: begin
                inst_valid = 1'b1;
                if (exec_ready) begin
                    retireNow = 1'b1;
                    stateNext = REQ;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            inst    <= 32'h0;
            retired <= 32'h0;
`ifdef DELAY_SLOT_EN
            pendingValid  <= 1'b0;
            pendingTarget <= 32'h0;
`endif
        end else begin
            if (fetchDone) begin
                inst <= imem_rdata;
            end
            if (retireNow) begin
                retired <= retired + 32'd1;
`ifdef DELAY_SLOT_EN
                // The delay slot's own redirect is dropped: the pending target wins.
                if (pendingValid) begin
                    pc           <= pendingTarget;
                    pendingValid <= 1'b0;
                end else if (redirect) begin
                    pendingTarget <= nextPc;
                    pendingValid  <= 1'b1;
                    pc            <= pc_plus4;
                end else begin
                    pc <= nextPc;
                end
`else
                pc <= nextPc;
`endif
            end
        end
    end

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - directed self-checking bench for inst_fetch

module tb_inst_fetch;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [1:0]  PCSrc;
    logic        branch_taken;
    logic [31:0] rs_data;
    logic        exec_ready;
    logic [31:0] inst;
    logic [5:0]  OpCode;
    logic [5:0]  Funct;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] retired;

    int          nChecks = 0;
    int          nPass   = 0;
    logic [31:0] expRetired = 0;
    logic [31:0] expPc = 0;

    inst_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .PCSrc(PCSrc), .branch_taken(branch_taken), .rs_data(rs_data),
        .exec_ready(exec_ready),
        .inst(inst), .OpCode(OpCode), .Funct(Funct), .inst_valid(inst_valid),
        .pc(pc), .pc_plus4(pc_plus4), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got === exp) nPass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Assumes REQ; ack arrives on the lat-th cycle of REQ.
    task automatic doFetch(input logic [31:0] word, input int lat);
        imem_rdata = word;
        for (int i = 0; i < lat - 1; i++) begin
            imem_ack = 1'b0;
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_valid", {31'd0, inst_valid}, 32'd0);
            tick();
        end
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        chk("fetch_inst", inst, word);
        chk("fetch_valid", {31'd0, inst_valid}, 32'd1);
    endtask

    task automatic retire(input logic [1:0] src, input logic bt, input logic [31:0] rs);
        PCSrc        = src;
        branch_taken = bt;
        rs_data      = rs;
        exec_ready   = 1'b1;
        tick();
        exec_ready   = 1'b0;
        PCSrc        = 2'd0;
        branch_taken = 1'b0;
        expRetired   = expRetired + 32'd1;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = 32'h0;
        PCSrc = 2'd0; branch_taken = 1'b0; rs_data = 32'h0; exec_ready = 1'b0;
        tick(); tick();
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_retired", retired, 32'h0);

        reset = 1'b0;
        chk("idle_req", {31'd0, imem_req}, 32'd0);
        tick();
        chk("req_rise", {31'd0, imem_req}, 32'd1);

        // Zero-latency sequential stream: one instruction every 2 cycles.
        imem_ack = 1'b1; imem_rdata = 32'h2008_0005; exec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("seq_addr", imem_addr, 32'(4 * i));
            chk("seq_retired_req", retired, 32'(i));
            tick();
            chk("seq_opcode", {26'd0, OpCode}, 32'h08);
            chk("seq_valid", {31'd0, inst_valid}, 32'd1);
            tick();
        end
        chk("seq_funct", {26'd0, Funct}, 32'h05);
        imem_ack = 1'b0; exec_ready = 1'b0;
        expRetired = 32'd3;
        chk("seq_retired", retired, expRetired);

        // Latency 3 at address 12.
        chk("lat_addr", imem_addr, 32'd12);
        doFetch(32'h1111_2222, 3);
        chk("lat_pc", pc, 32'd12);
        chk("lat_pc4", pc_plus4, 32'd16);
        retire(2'd0, 1'b0, 32'h0);
        chk("lat_next", imem_addr, 32'd16);

`ifdef DELAY_SLOT_EN
        doFetch(32'h0800_0008, 1);
        retire(2'd2, 1'b0, 32'h0);
        chk("ds_slot_a", imem_addr, 32'h14);
        doFetch(32'h0000_0000, 1);
        retire(2'd0, 1'b0, 32'h0);
        chk("ds_target_a", imem_addr, 32'h20);
        doFetch(32'h0800_0020, 1);
        retire(2'd2, 1'b0, 32'h0);
        chk("ds_slot_b", imem_addr, 32'h24);
        doFetch(32'h0800_0080, 1);
        retire(2'd2, 1'b0, 32'h0);
        chk("ds_target_b", imem_addr, 32'h80);
        expPc = 32'h80;
`else
        doFetch(32'h0800_0040, 1);
        retire(2'd2, 1'b0, 32'h0);
        chk("j_to_100", imem_addr, 32'h100);
        doFetch(32'h1000_FFFE, 1);
        retire(2'd1, 1'b1, 32'h0);
        chk("br_taken", imem_addr, 32'hFC);
        doFetch(32'h0800_0040, 1);
        retire(2'd2, 1'b0, 32'h0);
        chk("j_back_100", imem_addr, 32'h100);
        doFetch(32'h1000_FFFE, 2);
        retire(2'd1, 1'b0, 32'h0);
        chk("br_not_taken", imem_addr, 32'h104);
        doFetch(32'h0000_0008, 1);
        retire(2'd3, 1'b0, 32'h4000_0010);
        chk("jr_hi", imem_addr, 32'h4000_0010);
        doFetch(32'h0800_0040, 1);
        retire(2'd2, 1'b0, 32'h0);
        chk("j_region", imem_addr, 32'h4000_0100);
        doFetch(32'h0000_0008, 1);
        retire(2'd3, 1'b0, 32'h1237);
        chk("jr_mask", imem_addr, 32'h1234);
        doFetch(32'h0000_0008, 1);
        retire(2'd3, 1'b0, 32'hFFFF_FFFF);
        chk("jr_top", imem_addr, 32'hFFFF_FFFC);
        doFetch(32'h0000_0000, 1);
        retire(2'd0, 1'b0, 32'h0);
        chk("seq_wrap", imem_addr, 32'h0);
        doFetch(32'h1000_FFFE, 1);
        retire(2'd1, 1'b1, 32'h0);
        chk("br_wrap", imem_addr, 32'hFFFF_FFFC);
        expPc = 32'hFFFF_FFFC;
`endif

        // Stall: exec_ready low holds pc and inst.
        doFetch(32'hAAAA_5555, 1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_pc", pc, expPc);
            chk("stall_inst", inst, 32'hAAAA_5555);
            chk("stall_req", {31'd0, imem_req}, 32'd0);
        end
        retire(2'd0, 1'b0, 32'h0);
        chk("stall_next", imem_addr, expPc + 32'd4);
        chk("retired_total", retired, expRetired);

        // Reset during REQ with a simultaneous ack.
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF; reset = 1'b1;
        tick();
        reset = 1'b0; imem_ack = 1'b0;
        chk("mid_rst_inst", inst, 32'h0);
        chk("mid_rst_pc", pc, 32'h0);
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_retired", retired, 32'h0);
        tick();
        chk("post_rst_req", {31'd0, imem_req}, 32'd1);
        chk("post_rst_addr", imem_addr, 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
